// File: rtl/reservation_station.sv
// Reservation station for non-memory instructions. It holds entries until both operands are known and issues one per cycle to the ALU.
// Optional feature: define RS_WAKEUP_BYPASS_EN to let an entry issue in the same cycle its last operand appears on a CDB bus.
module reservation_station #(
    parameter int ADDR_WIDTH    = 32,
    parameter int RoB_WIDTH     = 8,
    parameter int EX_RoB_WIDTH  = 9,
    parameter logic [EX_RoB_WIDTH-1:0] NON_DEP = {1'b1, {(EX_RoB_WIDTH-1){1'b0}}},
    parameter int RS_SIZE_WIDTH = 4
) (
    input  logic                    Sys_clk,
    input  logic                    Sys_rst,
    input  logic                    Sys_rdy,
    input  logic                    DPRS_en,
    input  logic [ADDR_WIDTH-1:0]   DPRS_pc,
    input  logic [EX_RoB_WIDTH-1:0] DPRS_Qj,
    input  logic [EX_RoB_WIDTH-1:0] DPRS_Qk,
    input  logic [31:0]             DPRS_Vj,
    input  logic [31:0]             DPRS_Vk,
    input  logic [31:0]             DPRS_imm,
    input  logic [6:0]              DPRS_opcode,
    input  logic [RoB_WIDTH-1:0]    DPRS_RoB_index,
    output logic                    RSDP_full,
    input  logic                    CDBDP_RS_en,
    input  logic [RoB_WIDTH-1:0]    CDBDP_RS_RoB_index,
    input  logic [31:0]             CDBDP_RS_value,
    input  logic                    CDBDP_LSB_en,
    input  logic [RoB_WIDTH-1:0]    CDBDP_LSB_RoB_index,
    input  logic [31:0]             CDBDP_LSB_value,
    input  logic                    RoBRS_pre_judge,
    output logic                    RSALU_en,
    output logic [6:0]              RSALU_opcode,
    output logic [31:0]             RSALU_Vj,
    output logic [31:0]             RSALU_Vk,
    output logic [31:0]             RSALU_imm,
    output logic [ADDR_WIDTH-1:0]   RSALU_pc,
    output logic [RoB_WIDTH-1:0]    RSALU_RoB_index
);

    localparam int RS_SIZE = 1 << RS_SIZE_WIDTH;

    typedef logic [EX_RoB_WIDTH-1:0]  tag_t;
    typedef logic [RS_SIZE_WIDTH-1:0] slot_t;

    logic [RS_SIZE-1:0]    busy;
    tag_t                  qj     [RS_SIZE];
    tag_t                  qk     [RS_SIZE];
    logic [31:0]           vj     [RS_SIZE];
    logic [31:0]           vk     [RS_SIZE];
    logic [31:0]           imm    [RS_SIZE];
    logic [ADDR_WIDTH-1:0] pc     [RS_SIZE];
    logic [6:0]            opcode [RS_SIZE];
    logic [RoB_WIDTH-1:0]  rob    [RS_SIZE];

    logic                   free_valid;
    slot_t                  free_idx;
    logic                   issue_valid;
    slot_t                  issue_idx;
    logic [31:0]            issue_vj;
    logic [31:0]            issue_vk;
    tag_t                   dp_qj;
    tag_t                   dp_qk;
    logic [31:0]            dp_vj;
    logic [31:0]            dp_vk;
    logic [RS_SIZE_WIDTH:0] valid_count;
    logic [RS_SIZE_WIDTH+1:0] fill_level;
    logic                   flush;

    // A tag with its MSB set never matches: that is the "no dependency" marker.
    function automatic logic rs_hit(input tag_t tag);
        return CDBDP_RS_en && !tag[EX_RoB_WIDTH-1] && (tag[RoB_WIDTH-1:0] == CDBDP_RS_RoB_index);
    endfunction

    function automatic logic lsb_hit(input tag_t tag);
        return CDBDP_LSB_en && !tag[EX_RoB_WIDTH-1] && (tag[RoB_WIDTH-1:0] == CDBDP_LSB_RoB_index);
    endfunction

    function automatic logic snoop_hit(input tag_t tag);
        return rs_hit(tag) || lsb_hit(tag);
    endfunction

    function automatic logic [31:0] snoop_val(input tag_t tag);
        return rs_hit(tag) ? CDBDP_RS_value : CDBDP_LSB_value;
    endfunction

    function automatic logic operand_ready(input tag_t tag);
`ifdef RS_WAKEUP_BYPASS_EN
        return (tag == NON_DEP) || snoop_hit(tag);
`else
        return tag == NON_DEP;
`endif
    endfunction

    assign flush = Sys_rdy && !RoBRS_pre_judge;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch, so no latches are inferred.
        free_valid  = 1'b0;
        free_idx    = '0;
        issue_valid = 1'b0;
        issue_idx   = '0;
        valid_count = '0;
        // Scanning downwards leaves the lowest qualifying index as the winner.
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_valid = 1'b1;
                free_idx   = slot_t'(i);
            end
            if (busy[i] && operand_ready(qj[i]) && operand_ready(qk[i])) begin
                issue_valid = 1'b1;
                issue_idx   = slot_t'(i);
            end
            valid_count = valid_count + {{RS_SIZE_WIDTH{1'b0}}, busy[i]};
        end
    end

    always_comb begin
        issue_vj = vj[issue_idx];
        issue_vk = vk[issue_idx];
`ifdef RS_WAKEUP_BYPASS_EN
        if (snoop_hit(qj[issue_idx])) issue_vj = snoop_val(qj[issue_idx]);
        if (snoop_hit(qk[issue_idx])) issue_vk = snoop_val(qk[issue_idx]);
`endif
        dp_qj = snoop_hit(DPRS_Qj) ? NON_DEP : DPRS_Qj;
        dp_qk = snoop_hit(DPRS_Qk) ? NON_DEP : DPRS_Qk;
        dp_vj = snoop_hit(DPRS_Qj) ? snoop_val(DPRS_Qj) : DPRS_Vj;
        dp_vk = snoop_hit(DPRS_Qk) ? snoop_val(DPRS_Qk) : DPRS_Vk;
    end

    // One slot of headroom absorbs the dispatcher's registered enable.
    assign fill_level = {1'b0, valid_count} + {{(RS_SIZE_WIDTH+1){1'b0}}, DPRS_en};
    assign RSDP_full  = fill_level >= (RS_SIZE_WIDTH+2)'(RS_SIZE - 1);

    // Control state: occupancy, dependency tags and the issue port.
    always_ff @(posedge Sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
        if (Sys_rst || flush) begin
            busy            <= '0;
            RSALU_en        <= 1'b0;
            RSALU_opcode    <= '0;
            RSALU_Vj        <= '0;
            RSALU_Vk        <= '0;
            RSALU_imm       <= '0;
            RSALU_pc        <= '0;
            RSALU_RoB_index <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                qj[i] <= NON_DEP;
                qk[i] <= NON_DEP;
            end
        end else if (Sys_rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && snoop_hit(qj[i])) qj[i] <= NON_DEP;
                if (busy[i] && snoop_hit(qk[i])) qk[i] <= NON_DEP;
            end
            if (issue_valid) begin
                busy[issue_idx] <= 1'b0;
                RSALU_en        <= 1'b1;
                RSALU_opcode    <= opcode[issue_idx];
                RSALU_Vj        <= issue_vj;
                RSALU_Vk        <= issue_vk;
                RSALU_imm       <= imm[issue_idx];
                RSALU_pc        <= pc[issue_idx];
                RSALU_RoB_index <= rob[issue_idx];
            end else begin
                RSALU_en <= 1'b0;
            end
            if (DPRS_en && free_valid) begin
                busy[free_idx] <= 1'b1;
                qj[free_idx]   <= dp_qj;
                qk[free_idx]   <= dp_qk;
            end
            if (DPRS_en) begin
                assert (free_valid)
                else $error("reservation_station: dispatch with no free entry was dropped");
            end
        end
    end

    // NOTE: payload storage is deliberately not reset; busy and the tags alone decide whether it is used.
    always_ff @(posedge Sys_clk) begin
        if (Sys_rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && snoop_hit(qj[i])) vj[i] <= snoop_val(qj[i]);
                if (busy[i] && snoop_hit(qk[i])) vk[i] <= snoop_val(qk[i]);
            end
            if (DPRS_en && free_valid) begin
                vj[free_idx]     <= dp_vj;
                vk[free_idx]     <= dp_vk;
                imm[free_idx]    <= DPRS_imm;
                pc[free_idx]     <= DPRS_pc;
                opcode[free_idx] <= DPRS_opcode;
                rob[free_idx]    <= DPRS_RoB_index;
            end
        end
    end

endmodule
